// File: rtl/jellyvl_synctimer_pkg.sv
// Shared definitions for the synchronized-timer adjuster: FSM states and slew direction codes.
package jellyvl_synctimer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        SET    = 2'd2,
        ADJUST = 2'd3
    } state_t;

    localparam logic ADJUST_SIGN_SLOW = 1'b1;
    localparam logic ADJUST_SIGN_FAST = 1'b0;

endpackage

// File: rtl/jellyvl_synctimer_adjuster.sv
// Drift-correction initiator: compares a reference time sample with the local timer and issues a hard set
// or a paced series of one-tick slew requests. Define SYNCTIMER_ADJUSTER_MONITOR_EN to expose monitor outputs.
module jellyvl_synctimer_adjuster
    import jellyvl_synctimer_pkg::*;
#(
    parameter int unsigned              TIMER_WIDTH = 64,
    parameter int unsigned              ERROR_WIDTH = 16,
    parameter int unsigned              LIMIT       = 1000,
    parameter int unsigned              INTERVAL    = 4,
    parameter logic [TIMER_WIDTH-1:0]   SET_OFFSET  = TIMER_WIDTH'(0)
) (
    input  logic                    rst,
    input  logic                    clk,
    input  logic [TIMER_WIDTH-1:0]  current_time,
    input  logic [TIMER_WIDTH-1:0]  correct_time,
    input  logic                    correct_valid,
    output logic [TIMER_WIDTH-1:0]  set_time,
    output logic                    set_valid,
    output logic                    adjust_sign,
    output logic                    adjust_valid,
    input  logic                    adjust_ready,
    output logic                    busy,
    output logic [TIMER_WIDTH-1:0]  mon_error,
    output logic [ERROR_WIDTH-1:0]  mon_remain
);

    localparam int unsigned INTERVAL_BITS = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

    typedef logic [TIMER_WIDTH-1:0]   time_t;
    typedef logic [ERROR_WIDTH-1:0]   error_t;
    typedef logic [INTERVAL_BITS-1:0] interval_t;

    state_t    state_r,      state_s;
    time_t     diff_r,       diff_s;
    time_t     corr_r,       corr_s;
    time_t     set_time_r,   set_time_s;
    error_t    remain_r,     remain_s;
    interval_t intv_r,       intv_s;
    logic      sign_r,       sign_s;
    logic      adj_valid_r,  adj_valid_s;
    logic      set_valid_r,  set_valid_s;
    time_t     abs_s;
    logic      big_s;

    // Next-state and next-output computation; a new sample always preempts the current activity.
    always_comb begin
        state_s     = state_r;
        diff_s      = diff_r;
        corr_s      = corr_r;
        set_time_s  = set_time_r;
        remain_s    = remain_r;
        intv_s      = intv_r;
        sign_s      = sign_r;
        adj_valid_s = adj_valid_r;
        set_valid_s = 1'b0;
        abs_s       = diff_r[TIMER_WIDTH-1] ? (TIMER_WIDTH'(0) - diff_r) : diff_r;
        // most-negative error has no positive magnitude and is treated as out of range
        big_s       = abs_s[TIMER_WIDTH-1] || (abs_s > time_t'(LIMIT));

        if (correct_valid) begin
            diff_s      = correct_time - current_time;
            corr_s      = correct_time;
            remain_s    = error_t'(0);
            adj_valid_s = 1'b0;
            state_s     = CALC;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                CALC: begin
                    if (diff_r == time_t'(0)) begin
                        state_s = IDLE;
                    end else if (big_s) begin
                        set_valid_s = 1'b1;
                        set_time_s  = corr_r + SET_OFFSET;
                        state_s     = SET;
                    end else begin
                        remain_s    = abs_s[ERROR_WIDTH-1:0];
                        sign_s      = diff_r[TIMER_WIDTH-1] ? ADJUST_SIGN_SLOW : ADJUST_SIGN_FAST;
                        intv_s      = interval_t'(0);
                        adj_valid_s = 1'b1;
                        state_s     = ADJUST;
                    end
                end
                SET: begin
                    state_s = IDLE;
                end
                ADJUST: begin
                    if (adj_valid_r && adjust_ready) begin
                        remain_s = remain_r - error_t'(1);
                        intv_s   = interval_t'(INTERVAL - 1);
                        if (remain_r == error_t'(1)) begin
                            adj_valid_s = 1'b0;
                            state_s     = IDLE;
                        end else begin
                            adj_valid_s = (INTERVAL == 1);
                        end
                    end else if (!adj_valid_r) begin
                        // raise the request as the counter lands on zero so handshakes are INTERVAL apart
                        if (intv_r <= interval_t'(1)) begin
                            adj_valid_s = 1'b1;
                        end else begin
                            adj_valid_s = 1'b0;
                        end
                        if (intv_r != interval_t'(0)) begin
                            intv_s = intv_r - interval_t'(1);
                        end else begin
                            intv_s = intv_r;
                        end
                    end else begin
                        adj_valid_s = 1'b1;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            diff_r      <= time_t'(0);
            corr_r      <= time_t'(0);
            set_time_r  <= time_t'(0);
            remain_r    <= error_t'(0);
            intv_r      <= interval_t'(0);
            sign_r      <= 1'b0;
            adj_valid_r <= 1'b0;
            set_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            diff_r      <= diff_s;
            corr_r      <= corr_s;
            set_time_r  <= set_time_s;
            remain_r    <= remain_s;
            intv_r      <= intv_s;
            sign_r      <= sign_s;
            adj_valid_r <= adj_valid_s;
            set_valid_r <= set_valid_s;
        end
    end

    assign set_time     = set_time_r;
    assign set_valid    = set_valid_r;
    assign adjust_sign  = sign_r;
    assign adjust_valid = adj_valid_r;
    assign busy         = (state_r != IDLE);

`ifdef SYNCTIMER_ADJUSTER_MONITOR_EN
    assign mon_error  = diff_r;
    assign mon_remain = remain_r;
`else
    assign mon_error  = time_t'(0);
    assign mon_remain = error_t'(0);
`endif

endmodule

// File: tb/tb_jellyvl_synctimer_adjuster.sv
// Self-checking bench for jellyvl_synctimer_adjuster: directed table, hand sequences and random stimulus vs a model.
module tb_jellyvl_synctimer_adjuster;

    localparam int          TW       = 64;
    localparam int          EW       = 16;
    localparam int          LIMIT    = 1000;
    localparam int          INTERVAL = 4;
    localparam logic [63:0] OFFSET   = 64'd7;

    logic          clk = 1'b0;
    logic          rst;
    logic [TW-1:0] current_time, correct_time, set_time, mon_error;
    logic          correct_valid, set_valid, adjust_sign, adjust_valid, adjust_ready, busy;
    logic [EW-1:0] mon_remain;

    int n_cmp = 0;
    int n_err = 0;

    jellyvl_synctimer_adjuster #(
        .TIMER_WIDTH(TW), .ERROR_WIDTH(EW), .LIMIT(LIMIT), .INTERVAL(INTERVAL), .SET_OFFSET(OFFSET)
    ) dut (
        .rst(rst), .clk(clk), .current_time(current_time), .correct_time(correct_time),
        .correct_valid(correct_valid), .set_time(set_time), .set_valid(set_valid),
        .adjust_sign(adjust_sign), .adjust_valid(adjust_valid), .adjust_ready(adjust_ready),
        .busy(busy), .mon_error(mon_error), .mon_remain(mon_remain)
    );

    always #5 clk = ~clk;

    // reference model: pending sample, set phase, ticks left and the edge at which the next request is due
    longint      k = 0;
    logic        m_pend = 1'b0, m_setph = 1'b0, m_sign = 1'b0;
    logic [63:0] p_diff = 64'd0, p_corr = 64'd0, m_mon_err = 64'd0;
    int          m_left = 0;
    longint      m_next = 0;
    logic        e_set_valid = 1'b0, e_adj_valid = 1'b0;
    logic [63:0] e_set_time = 64'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic signed [64:0] d65;
        logic [64:0]        mag;
        logic               hs;
        hs = e_adj_valid && adjust_ready;
        e_set_valid = 1'b0;
        k++;
        if (rst) begin
            m_pend = 1'b0; m_setph = 1'b0; m_sign = 1'b0; m_left = 0;
            p_diff = 64'd0; p_corr = 64'd0; m_mon_err = 64'd0; e_set_time = 64'd0;
        end else if (correct_valid) begin
            m_pend = 1'b1; m_setph = 1'b0; m_left = 0;
            p_diff = correct_time - current_time; p_corr = correct_time; m_mon_err = p_diff;
        end else if (m_pend) begin
            m_pend = 1'b0;
            d65 = {p_diff[63], p_diff};
            mag = (d65 < 0) ? 65'(-d65) : 65'(d65);
            if (mag == 65'd0) begin
                m_left = 0;
            end else if (mag > 65'(LIMIT)) begin
                e_set_valid = 1'b1; e_set_time = p_corr + OFFSET; m_setph = 1'b1;
            end else begin
                m_left = int'(mag); m_sign = (d65 < 0); m_next = k;
            end
        end else if (m_setph) begin
            m_setph = 1'b0;
        end else if (m_left > 0 && hs) begin
            m_left--;
            m_next = k + INTERVAL - 1;
        end
        e_adj_valid = (m_left > 0) && (k >= m_next);
    endtask

    task automatic check_all();
        chk("set_valid", 64'(set_valid), 64'(e_set_valid));
        chk("set_time", set_time, e_set_time);
        chk("adjust_valid", 64'(adjust_valid), 64'(e_adj_valid));
        chk("adjust_sign", 64'(adjust_sign), 64'(m_sign));
        chk("busy", 64'(busy), 64'(m_pend || m_setph || (m_left > 0)));
`ifdef SYNCTIMER_ADJUSTER_MONITOR_EN
        chk("mon_error", mon_error, m_mon_err);
        chk("mon_remain", 64'(mon_remain), 64'(m_left));
`else
        chk("mon_error", mon_error, 64'd0);
        chk("mon_remain", 64'(mon_remain), 64'd0);
`endif
    endtask

    task automatic step(input logic r, input logic cv, input logic [63:0] cur, input logic [63:0] ct,
                        input logic rdy);
        rst = r; correct_valid = cv; current_time = cur; correct_time = ct; adjust_ready = rdy;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    typedef struct {
        logic [63:0] cur;
        logic [63:0] ct;
        int          hs;
        logic        sgn;
        int          sets;
        logic [63:0] st;
        int          bcyc;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int hs, sets, bcyc, bad_gap, bad_sgn, last, edge_no, cnt;
        logic [63:0] st, cur, ct;
        longint sd;

        vecs[0] = '{64'd1000, 64'd1003, 3, 1'b0, 0, 64'd0, 10};
        vecs[1] = '{64'd1000, 64'd997, 3, 1'b1, 0, 64'd0, 10};
        vecs[2] = '{64'd1000, 64'd1000, 0, 1'b0, 0, 64'd0, 1};
        vecs[3] = '{64'd0, 64'd5000, 0, 1'b0, 1, 64'd5007, 2};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 3, 1'b0, 0, 64'd0, 10};
        vecs[5] = '{64'd0, 64'd1000, 1000, 1'b0, 0, 64'd0, 3998};
        vecs[6] = '{64'd0, 64'd1001, 0, 1'b0, 1, 64'd1008, 2};
        vecs[7] = '{64'd5000, 64'd4000, 1000, 1'b1, 0, 64'd0, 3998};
        vecs[8] = '{64'd0, 64'h8000_0000_0000_0000, 0, 1'b0, 1, 64'h8000_0000_0000_0007, 2};
        vecs[9] = '{64'd1000, 64'd999, 1, 1'b1, 0, 64'd0, 2};

        rst = 1'b1; correct_valid = 1'b0; current_time = 64'd0; correct_time = 64'd0; adjust_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("reset_busy", 64'(busy), 64'd0);

        // directed table: run each sample to completion with ready tied high
        for (int i = 0; i < 10; i++) begin
            hs = 0; sets = 0; bcyc = 0; bad_gap = 0; bad_sgn = 0; last = -1; edge_no = 0; st = 64'd0;
            step(1'b0, 1'b1, vecs[i].cur, vecs[i].ct, 1'b1);
            if (busy) bcyc++;
            for (int c = 0; c < 5000 && busy; c++) begin
                if (adjust_valid) begin
                    hs++;
                    if (last >= 0 && (edge_no + 1 - last) != INTERVAL) bad_gap++;
                    last = edge_no + 1;
                    if (adjust_sign !== vecs[i].sgn) bad_sgn++;
                end
                step(1'b0, 1'b0, 64'd0, 64'd0, 1'b1);
                edge_no++;
                if (busy) bcyc++;
                if (set_valid) begin sets++; st = set_time; end
            end
            chk("tbl_timeout", 64'(busy), 64'd0);
            chk("tbl_handshakes", 64'(hs), 64'(vecs[i].hs));
            chk("tbl_sets", 64'(sets), 64'(vecs[i].sets));
            chk("tbl_set_time", st, vecs[i].st);
            chk("tbl_busy_cycles", 64'(bcyc), 64'(vecs[i].bcyc));
            chk("tbl_gap", 64'(bad_gap), 64'd0);
            chk("tbl_sign", 64'(bad_sgn), 64'd0);
            for (int c = 0; c < 2; c++) step(1'b0, 1'b0, 64'd0, 64'd0, 1'b1);
        end

        // ready held low: request and sign must stay put; then a new sample preempts the slew
        step(1'b0, 1'b1, 64'd1000, 64'd1010, 1'b0);
        step(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
            chk("stall_valid", 64'(adjust_valid), 64'd1);
            chk("stall_sign", 64'(adjust_sign), 64'd0);
        end
        step(1'b0, 1'b1, 64'd2000, 64'd1995, 1'b1);
        chk("preempt_drop", 64'(adjust_valid), 64'd0);
        step(1'b0, 1'b0, 64'd0, 64'd0, 1'b1);
        chk("preempt_restart", 64'(adjust_valid), 64'd1);
        chk("preempt_sign", 64'(adjust_sign), 64'd1);
        hs = 0;
        for (int c = 0; c < 100 && busy; c++) begin
            if (adjust_valid) hs++;
            step(1'b0, 1'b0, 64'd0, 64'd0, 1'b1);
        end
        chk("preempt_handshakes", 64'(hs), 64'd5);

        // reset held mid-slew: everything clears and stays quiet
        step(1'b0, 1'b1, 64'd1000, 64'd1500, 1'b1);
        for (int c = 0; c < 20; c++) step(1'b0, 1'b0, 64'd0, 64'd0, 1'b1);
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 64'd0, 64'd0, 1'b1);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b0, 64'd0, 64'd0, 1'b1);
            if (set_valid || adjust_valid || busy) cnt++;
        end
        chk("post_reset_quiet", 64'(cnt), 64'd0);

        // random stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            cur = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: sd = longint'($urandom_range(0, 40)) - 64'sd20;
                1: sd = longint'($urandom_range(0, 2400)) - 64'sd1200;
                2: sd = 64'sd0;
                default: sd = longint'({$urandom, $urandom});
            endcase
            ct = cur + 64'(sd);
            step(($urandom_range(0, 599) == 0), ($urandom_range(0, 29) == 0), cur, ct,
                 ($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
